// File: rtl/connector_pkg.sv
// Field widths shared with cva6_te_connector and the buffered ingress block layout.
package connector_pkg;

  localparam int unsigned IRETIRE_LEN = 32;
  localparam int unsigned ITYPE_LEN   = 3;
  localparam int unsigned CAUSE_LEN   = 5;
  localparam int unsigned PRIV_LEN    = 2;
  localparam int unsigned XLEN        = 32;

  // One buffered ingress block; shared fields are replicated per entry.
  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        iaddr;
  } te_entry_t;

endpackage

// File: rtl/te_ingress_receiver_if.sv
// Ingress bus from the connector plus the single-block encoder handshake.
interface te_ingress_receiver_if
  import connector_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

  logic [N-1:0]                  valid_i;
  logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]                  ilastsize_i;
  logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
  logic [CAUSE_LEN-1:0]          cause_i;
  logic [XLEN-1:0]               tval_i;
  logic [PRIV_LEN-1:0]           priv_i;
  logic [N-1:0][XLEN-1:0]        iaddr_i;
  logic                          ready_i;

  logic                          valid_o;
  logic [IRETIRE_LEN-1:0]        iretire_o;
  logic                          ilastsize_o;
  logic [ITYPE_LEN-1:0]          itype_o;
  logic [CAUSE_LEN-1:0]          cause_o;
  logic [XLEN-1:0]               tval_o;
  logic [PRIV_LEN-1:0]           priv_o;
  logic [XLEN-1:0]               iaddr_o;
  logic [FILL_W-1:0]             fill_o;
  logic                          overflow_o;

  modport master (
    output valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
    input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
           fill_o, overflow_o
  );

  modport slave (
    input  valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
    output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
           fill_o, overflow_o
  );

endinterface

// File: rtl/te_ingress_receiver.sv
// Compacts up to N ingress blocks per cycle into a circular FIFO and replays
// them one block per cycle to the trace encoder; whole groups drop on overflow.
module te_ingress_receiver
  import connector_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 8
) (
  input logic                clk_i,
  input logic                rst_ni,
  te_ingress_receiver_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(N + 1);

  te_entry_t         mem_q [DEPTH];
  te_entry_t         mem_d [DEPTH];
  te_entry_t         blk     [N];
  te_entry_t         wr_data [N];
  logic [CNT_W-1:0]  pre_cnt [N];
  logic [CNT_W-1:0]  push_cnt;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FILL_W-1:0] fill_q, fill_d, free_slots;
  logic              valid_q, overflow_q, overflow_d;
  logic              pop, accept;
  te_entry_t         head_q, head_d;

  // Per-block payload with the shared cycle fields replicated in.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      blk[i] = '{iretire:   bus.iretire_i[i],
                 ilastsize: bus.ilastsize_i[i],
                 itype:     bus.itype_i[i],
                 cause:     bus.cause_i,
                 tval:      bus.tval_i,
                 priv:      bus.priv_i,
                 iaddr:     bus.iaddr_i[i]};
    end
  end

  // Prefix count of valid blocks gives each valid block its compacted lane.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pre_cnt[i] = push_cnt;
      push_cnt   = push_cnt + CNT_W'(bus.valid_i[i]);
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      wr_data[j] = '0;
      for (int i = 0; i < N; i++) begin
        if (bus.valid_i[i] && (pre_cnt[i] == CNT_W'(j))) wr_data[j] = blk[i];
      end
    end
  end

  // A same-cycle pop frees a slot for the incoming group.
  always_comb begin
    pop        = valid_q && bus.ready_i;
    free_slots = FILL_W'(DEPTH) - fill_q + FILL_W'(pop);
    accept     = FILL_W'(push_cnt) <= free_slots;
    overflow_d = overflow_q | ~accept;
    fill_d     = fill_q + (accept ? FILL_W'(push_cnt) : '0) - FILL_W'(pop);
    wptr_d     = wptr_q + (accept ? PTR_W'(push_cnt) : '0);
    rptr_d     = rptr_q + PTR_W'(pop);
  end

  // Next memory image; a group may straddle the wrap from DEPTH-1 to 0.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      mem_d[s] = mem_q[s];
      for (int j = 0; j < N; j++) begin
        if (accept && (CNT_W'(j) < push_cnt) &&
            (PTR_W'(wptr_q + PTR_W'(j)) == PTR_W'(s))) begin
          mem_d[s] = wr_data[j];
        end
      end
    end
  end

  // Head block registered from the next-state image, zero while empty.
  always_comb begin
    head_d = '0;
    if (fill_d != '0) head_d = mem_d[rptr_d];
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < DEPTH; s++) mem_q[s] <= mem_d[s];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fill_q     <= fill_d;
      valid_q    <= fill_d != '0;
      overflow_q <= overflow_d;
      head_q     <= head_d;
    end
  end

  assign bus.valid_o     = valid_q;
  assign bus.iretire_o   = head_q.iretire;
  assign bus.ilastsize_o = head_q.ilastsize;
  assign bus.itype_o     = head_q.itype;
  assign bus.cause_o     = head_q.cause;
  assign bus.tval_o      = head_q.tval;
  assign bus.priv_o      = head_q.priv;
  assign bus.iaddr_o     = head_q.iaddr;
  assign bus.fill_o      = fill_q;
  assign bus.overflow_o  = overflow_q;

endmodule

// File: tb/tb_te_ingress_receiver.sv
// Directed bench for te_ingress_receiver with hand-computed expectations.
module tb_te_ingress_receiver;
  import connector_pkg::*;

  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  te_ingress_receiver_if #(.N(N), .DEPTH(DEPTH)) bus ();

  te_ingress_receiver #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.valid_i     = '0;
    bus.iretire_i   = '0;
    bus.ilastsize_i = '0;
    bus.itype_i     = '0;
    bus.cause_i     = '0;
    bus.tval_i      = '0;
    bus.priv_i      = '0;
    bus.iaddr_i     = '0;
  endtask

  logic [XLEN-1:0] exp5 [8];

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    checks   = 0;
    failures = 0;
    idle_inputs();
    bus.ready_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // 1: reset then idle
    for (int c = 0; c < 5; c++) step();
    chk("idle_valid",    64'(bus.valid_o),    64'd0);
    chk("idle_fill",     64'(bus.fill_o),     64'd0);
    chk("idle_overflow", 64'(bus.overflow_o), 64'd0);
    chk("idle_iaddr",    64'(bus.iaddr_o),    64'd0);
    chk("idle_tval",     64'(bus.tval_o),     64'd0);
    chk("idle_priv",     64'(bus.priv_o),     64'd0);
    chk("idle_cause",    64'(bus.cause_o),    64'd0);
    chk("idle_itype",    64'(bus.itype_o),    64'd0);
    chk("idle_iretire",  64'(bus.iretire_o),  64'd0);

    // 2: dual push with encoder stalled
    bus.valid_i      = 2'b11;
    bus.iaddr_i[0]   = 32'h8000_0000;
    bus.iaddr_i[1]   = 32'h8000_0010;
    bus.iretire_i[0] = 32'd3;
    bus.iretire_i[1] = 32'd7;
    bus.ilastsize_i  = 2'b10;
    bus.priv_i       = 2'd3;
    step();
    idle_inputs();
    chk("dual_valid",   64'(bus.valid_o),     64'd1);
    chk("dual_iaddr0",  64'(bus.iaddr_o),     64'h8000_0000);
    chk("dual_priv0",   64'(bus.priv_o),      64'd3);
    chk("dual_fill",    64'(bus.fill_o),      64'd2);
    chk("dual_iret0",   64'(bus.iretire_o),   64'd3);
    chk("dual_lsz0",    64'(bus.ilastsize_o), 64'd0);
    step();
    chk("stall_iaddr",  64'(bus.iaddr_o),     64'h8000_0000);
    chk("stall_fill",   64'(bus.fill_o),      64'd2);
    bus.ready_i = 1'b1;
    step();
    chk("dual_iaddr1",  64'(bus.iaddr_o),     64'h8000_0010);
    chk("dual_priv1",   64'(bus.priv_o),      64'd3);
    chk("dual_iret1",   64'(bus.iretire_o),   64'd7);
    chk("dual_lsz1",    64'(bus.ilastsize_o), 64'd1);
    chk("dual_fill1",   64'(bus.fill_o),      64'd1);
    step();
    chk("dual_empty",   64'(bus.valid_o),     64'd0);
    chk("dual_zero",    64'(bus.iaddr_o),     64'd0);
    bus.ready_i = 1'b0;

    // 3: sparse compaction, block 0 must be skipped
    bus.valid_i    = 2'b10;
    bus.itype_i[0] = 3'd5;
    bus.itype_i[1] = 3'd1;
    bus.iaddr_i[0] = 32'h0000_000B;
    bus.iaddr_i[1] = 32'h0000_000A;
    bus.cause_i    = 5'd5;
    bus.tval_i     = 32'h1234;
    step();
    idle_inputs();
    chk("sparse_fill",  64'(bus.fill_o),  64'd1);
    chk("sparse_itype", 64'(bus.itype_o), 64'd1);
    chk("sparse_cause", 64'(bus.cause_o), 64'd5);
    chk("sparse_tval",  64'(bus.tval_o),  64'h1234);
    chk("sparse_iaddr", 64'(bus.iaddr_o), 64'hA);
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    chk("sparse_drain", 64'(bus.fill_o), 64'd0);

    // 4: overflow drops the whole group and stays sticky
    for (int c = 0; c < 4; c++) begin
      bus.valid_i    = 2'b11;
      bus.iaddr_i[0] = 32'(32'h100 + 2 * c);
      bus.iaddr_i[1] = 32'(32'h101 + 2 * c);
      step();
    end
    chk("full_fill", 64'(bus.fill_o),     64'd8);
    chk("full_ovf",  64'(bus.overflow_o), 64'd0);
    bus.iaddr_i[0] = 32'h200;
    bus.iaddr_i[1] = 32'h201;
    step();
    idle_inputs();
    chk("ovf_fill", 64'(bus.fill_o),     64'd8);
    chk("ovf_flag", 64'(bus.overflow_o), 64'd1);
    bus.ready_i = 1'b1;
    for (int e = 0; e < 8; e++) begin
      chk("ovf_drain", 64'(bus.iaddr_o), 64'(32'h100 + e));
      step();
    end
    bus.ready_i = 1'b0;
    chk("ovf_empty",  64'(bus.valid_o),    64'd0);
    chk("ovf_sticky", 64'(bus.overflow_o), 64'd1);

    // clear the sticky flag
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_ovf",  64'(bus.overflow_o), 64'd0);
    chk("rst_fill", 64'(bus.fill_o),     64'd0);

    // 5: full with a simultaneous pop accepts a two-block group
    for (int c = 0; c < 3; c++) begin
      bus.valid_i    = 2'b11;
      bus.iaddr_i[0] = 32'(32'h300 + 2 * c);
      bus.iaddr_i[1] = 32'(32'h301 + 2 * c);
      step();
    end
    bus.valid_i    = 2'b01;
    bus.iaddr_i[0] = 32'h306;
    step();
    chk("p5_fill7", 64'(bus.fill_o), 64'd7);
    bus.valid_i    = 2'b11;
    bus.iaddr_i[0] = 32'h310;
    bus.iaddr_i[1] = 32'h311;
    bus.ready_i    = 1'b1;
    step();
    idle_inputs();
    bus.ready_i = 1'b0;
    chk("p5_fill8", 64'(bus.fill_o),     64'd8);
    chk("p5_ovf",   64'(bus.overflow_o), 64'd0);
    exp5[0] = 32'h301; exp5[1] = 32'h302; exp5[2] = 32'h303; exp5[3] = 32'h304;
    exp5[4] = 32'h305; exp5[5] = 32'h306; exp5[6] = 32'h310; exp5[7] = 32'h311;
    bus.ready_i = 1'b1;
    for (int e = 0; e < 8; e++) begin
      chk("p5_drain", 64'(bus.iaddr_o), 64'(exp5[e]));
      step();
    end
    chk("p5_empty", 64'(bus.valid_o), 64'd0);

    // 6: streaming single blocks across the pointer wrap
    for (int i = 0; i < 11; i++) begin
      bus.valid_i    = 2'b01;
      bus.iaddr_i[0] = 32'(32'h400 + i);
      step();
      chk("wrap_iaddr", 64'(bus.iaddr_o), 64'(32'h400 + i));
      chk("wrap_fill",  64'(bus.fill_o),  64'd1);
    end
    idle_inputs();
    step();
    bus.ready_i = 1'b0;
    chk("wrap_empty", 64'(bus.valid_o), 64'd0);

    // reset with three entries buffered
    bus.valid_i    = 2'b11;
    bus.iaddr_i[0] = 32'h450;
    bus.iaddr_i[1] = 32'h451;
    step();
    bus.valid_i    = 2'b01;
    bus.iaddr_i[0] = 32'h452;
    step();
    idle_inputs();
    chk("pre_rst_fill", 64'(bus.fill_o), 64'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_fill",  64'(bus.fill_o),  64'd0);
    chk("mid_rst_valid", 64'(bus.valid_o), 64'd0);
    chk("mid_rst_iaddr", 64'(bus.iaddr_o), 64'd0);
    bus.valid_i    = 2'b01;
    bus.iaddr_i[0] = 32'h500;
    step();
    idle_inputs();
    chk("post_rst_iaddr", 64'(bus.iaddr_o), 64'h500);
    chk("post_rst_fill",  64'(bus.fill_o),  64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/te_ingress_receiver.md
Name: te_ingress_receiver

Overview:
- Sink end of the trace-encoder ingress interface driven by cva6_te_connector.
- Accepts up to N ingress blocks per cycle and compacts the valid ones in index order.
- Buffers them in a circular FIFO, then presents them one block per cycle over a valid/ready handshake to a single-block trace encoder.
- Shared per-cycle fields (cause, tval, priv) are replicated into every block pushed in that cycle.

Parameters:
- N, 2, number of ingress blocks per cycle; must equal the connector's N.
- DEPTH, 8, FIFO entries; power of two, DEPTH >= N.
- Field widths IRETIRE_LEN, ITYPE_LEN, CAUSE_LEN, PRIV_LEN, XLEN come from connector_pkg.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_ni  in  1  reset; synchronous, active-low.
- valid_i  in  N  per-block valid.
- iretire_i  in  N x IRETIRE_LEN  per-block retired halfword count.
- ilastsize_i  in  N  per-block last instruction size.
- itype_i  in  N x ITYPE_LEN  per-block type.
- cause_i  in  CAUSE_LEN  shared exception/interrupt cause.
- tval_i  in  XLEN  shared trap value.
- priv_i  in  PRIV_LEN  shared privilege level.
- iaddr_i  in  N x XLEN  per-block address.
- ready_i  in  1  encoder accepts the head block.
- valid_o  out  1  head block available.
- iretire_o  out  IRETIRE_LEN  head block retired halfword count.
- ilastsize_o  out  1  head block last instruction size.
- itype_o  out  ITYPE_LEN  head block type.
- cause_o  out  CAUSE_LEN  head block cause.
- tval_o  out  XLEN  head block trap value.
- priv_o  out  PRIV_LEN  head block privilege level.
- iaddr_o  out  XLEN  head block address.
- fill_o  out  clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky drop flag.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - Write and read pointers = 0, occupancy = 0, overflow_o = 0.
  - Applies mid-operation: all buffered blocks are discarded; the first cycle after reset shows valid_o=0.
- Entry format: {iretire, ilastsize, itype, cause, tval, priv, iaddr}.
- Push group: k = popcount(valid_i).
  - Valid blocks are written to consecutive slots from the write pointer, lowest index first; gaps are skipped.
  - Example: valid_i=2'b10 writes only block 1, to slot wptr.
- Pop: occurs when valid_o && ready_i.
  - The read pointer advances by 1 in the same cycle.
  - At most one pop per cycle.
- Space check: free = DEPTH - fill + pop_this_cycle, so a simultaneous pop frees a slot for the same-cycle push.
- Push rule: if k <= free, all k blocks are written. Otherwise the whole group is dropped (no partial push) and overflow_o is set. overflow_o stays high until reset.
- Occupancy next = fill + (accepted ? k : 0) - pop.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. A group may straddle the wrap boundary: slots DEPTH-1 then 0.
- Latency: a block pushed at edge t is visible at valid_o after edge t. Minimum one cycle; there is no combinational input-to-output bypass.
- Output timing: valid_o = (fill_o != 0).
  - Data outputs are a combinational read of the head slot.
  - Data outputs are forced to 0 when valid_o=0.
  - Data outputs are stable while valid_o=1 && ready_i=0.
- Ordering: strict FIFO across cycles; within a cycle, index order.
- Empty with k=0: no state change. Full with k=0 and a pop: fill decrements normally.
- fill_o never exceeds DEPTH. There is no underflow: a pop is impossible when empty.

Test Plan:
1. Reset then idle: valid_i=0 for 5 cycles -> valid_o=0, fill_o=0, overflow_o=0, all data outputs 0.
2. Dual push with encoder stalled:
   - Stimulus: valid_i=2'b11 with iaddr_i={0x80000010,0x80000000}, priv_i=3, ready_i=0.
   - Next cycle: valid_o=1, iaddr_o=0x80000000, priv_o=3, fill_o=2.
   - Raise ready_i: 0x80000010 is presented next, then valid_o=0.
3. Sparse compaction: valid_i=2'b10, itype_i[1]=1, cause_i=5, tval_i=0x1234 -> one entry, itype_o=1, cause_o=5, tval_o=0x1234, fill_o=1.
4. Overflow:
   - Stimulus: DEPTH=8, ready_i=0; push 2 blocks for 4 cycles (fill_o=8), then push 2 more.
   - Required: group dropped, fill_o stays 8, overflow_o=1.
   - After draining 8 entries in order, overflow_o is still 1.
5. Full plus simultaneous pop:
   - Stimulus: fill_o=7, ready_i=1, valid_i=2'b11.
   - Required: free=2, group accepted, fill_o=8, no overflow.
6. Wrap and reset:
   - Stimulus: push/pop 11 single blocks with incrementing iaddr.
   - Required: outputs appear in order across the pointer wrap.
   - Then assert rst_ni=0 with fill_o=3 -> next cycle fill_o=0, valid_o=0.
